// File: rtl/writeback_ledger_if.sv
// Allocation, completion, flush and retirement signals of the writeback ledger.
// The slave modport is the ledger itself; the master modport is whoever drives it.
interface writeback_ledger_if #(
  parameter int DEPTH = 8,
  parameter int NR_W  = 4,
  parameter int TAG_W = 5
);
  localparam int IDX_W = $clog2(DEPTH);

  logic             alloc;
  logic [NR_W-1:0]  alloc_nr;
  logic [TAG_W-1:0] alloc_tag;
  logic             alloc_ready;
  logic [IDX_W-1:0] alloc_idx;
  logic             done;
  logic [IDX_W-1:0] done_idx;
  logic             flush;
  logic             retire_valid;
  logic [NR_W-1:0]  retire_nr;
  logic [TAG_W-1:0] retire_tag;
  logic [IDX_W:0]   count;
  logic             empty;
  logic             full;

  modport master (
    output alloc, alloc_nr, alloc_tag, done, done_idx, flush,
    input  alloc_ready, alloc_idx, retire_valid, retire_nr, retire_tag,
           count, empty, full
  );

  modport slave (
    input  alloc, alloc_nr, alloc_tag, done, done_idx, flush,
    output alloc_ready, alloc_idx, retire_valid, retire_nr, retire_tag,
           count, empty, full
  );
endinterface

// File: rtl/writeback_ledger.sv
// In-order ledger of renamed writebacks: allocate at tail, complete in any order,
// retire from head one entry per cycle and hand the freed tag back to the renamer.
module writeback_ledger #(
  parameter int DEPTH = 8,
  parameter int NR_W  = 4,
  parameter int TAG_W = 5
) (
  input  logic              clk,
  input  logic              notrst,
  writeback_ledger_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [NR_W-1:0]  nr_q  [DEPTH];
  logic [TAG_W-1:0] tag_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic             retire_valid_q, retire_valid_d;
  logic [NR_W-1:0]  retire_nr_q, retire_nr_d;
  logic [TAG_W-1:0] retire_tag_q, retire_tag_d;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] tail_idx;
  logic             full;
  logic             empty;
  logic             alloc_fire;
  logic             done_fire;
  logic             retire_fire;

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

  // Full is judged on pre-edge state, so a retire at the same edge never admits an alloc.
  assign alloc_fire  = bus.alloc && !full;
  assign done_fire   = bus.done && valid_q[bus.done_idx] && !done_q[bus.done_idx];
  assign retire_fire = valid_q[head_idx] && done_q[head_idx];

  always_comb begin
    valid_d        = valid_q;
    done_d         = done_q;
    head_d         = head_q;
    tail_d         = tail_q;
    retire_valid_d = 1'b0;
    retire_nr_d    = retire_nr_q;
    retire_tag_d   = retire_tag_q;
    if (bus.flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (retire_fire) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + PTR_W'(1);
        retire_valid_d    = 1'b1;
        retire_nr_d       = nr_q[head_idx];
        retire_tag_d      = tag_q[head_idx];
      end
      if (done_fire) begin
        done_d[bus.done_idx] = 1'b1;
      end
      // The tail slot is free whenever alloc fires, so this never collides with head.
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge notrst) begin
    if (!notrst) begin
      valid_q        <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      retire_valid_q <= 1'b0;
      retire_nr_q    <= '0;
      retire_tag_q   <= '0;
    end else begin
      valid_q        <= valid_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      retire_valid_q <= retire_valid_d;
      retire_nr_q    <= retire_nr_d;
      retire_tag_q   <= retire_tag_d;
    end
  end

  // Payload is only meaningful while valid is set, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire && !bus.flush) begin
      nr_q[tail_idx]  <= bus.alloc_nr;
      tag_q[tail_idx] <= bus.alloc_tag;
    end
  end

  assign bus.alloc_ready  = !full;
  assign bus.alloc_idx    = tail_idx;
  assign bus.retire_valid = retire_valid_q;
  assign bus.retire_nr    = retire_nr_q;
  assign bus.retire_tag   = retire_tag_q;
  assign bus.count        = tail_q - head_q;
  assign bus.empty        = empty;
  assign bus.full         = full;
endmodule

// File: tb/tb_writeback_ledger.sv
// Directed bench for writeback_ledger: reset, in-order retire, full, wrap,
// illegal completions and flush, each with hand-computed expectations.
module tb_writeback_ledger;
  logic clk;
  logic notrst;
  int   n_vec;
  int   n_err;

  writeback_ledger_if #(.DEPTH(8), .NR_W(4), .TAG_W(5)) bus ();

  writeback_ledger #(.DEPTH(8), .NR_W(4), .TAG_W(5)) dut (
    .clk    (clk),
    .notrst (notrst),
    .bus    (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alloc     = 1'b0;
    bus.alloc_nr  = '0;
    bus.alloc_tag = '0;
    bus.done      = 1'b0;
    bus.done_idx  = '0;
    bus.flush     = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    notrst = 1'b0;
    #3;
    @(negedge clk);
    notrst = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    notrst = 1'b0;
    #12;
    notrst = 1'b1;
    @(negedge clk);
    bus.alloc = 1'b1; bus.alloc_nr = 4'd5; bus.alloc_tag = 5'd6;
    tick();
    bus.alloc_nr = 4'd6; bus.alloc_tag = 5'd7;
    bus.done = 1'b1; bus.done_idx = 3'd0;
    tick();
    idle();
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset_retire got %0b required 1", bus.retire_valid);
    end
    #2;
    notrst = 1'b0;
    #1;
    n_vec++;
    if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.count !== 4'd0) begin
      n_err++; $display("FAIL reset_occupancy got empty=%0b full=%0b count=%0d required 1 0 0",
                        bus.empty, bus.full, bus.count);
    end
    n_vec++;
    if (bus.alloc_ready !== 1'b1 || bus.alloc_idx !== 3'd0) begin
      n_err++; $display("FAIL reset_alloc got ready=%0b idx=%0d required 1 0",
                        bus.alloc_ready, bus.alloc_idx);
    end
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.retire_nr !== 4'd0 || bus.retire_tag !== 5'd0) begin
      n_err++; $display("FAIL reset_retire got v=%0b nr=%0d tag=%0d required 0 0 0",
                        bus.retire_valid, bus.retire_nr, bus.retire_tag);
    end
    @(negedge clk);
    notrst = 1'b1;
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.count !== 4'd0) begin
      n_err++; $display("FAIL post_reset got v=%0b count=%0d required 0 0",
                        bus.retire_valid, bus.count);
    end
  endtask

  task automatic test_in_order();
    logic [3:0] nrs  [3] = '{4'd3, 4'd7, 4'd1};
    logic [4:0] tags [3] = '{5'd5, 5'd9, 5'd2};
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.alloc_idx !== 3'(i)) begin
        n_err++; $display("FAIL inorder_alloc_idx got %0d required %0d", bus.alloc_idx, i);
      end
      bus.alloc = 1'b1; bus.alloc_nr = nrs[i]; bus.alloc_tag = tags[i];
      tick();
    end
    idle();
    bus.done = 1'b1; bus.done_idx = 3'd2;
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.count !== 4'd3) begin
      n_err++; $display("FAIL inorder_no_early got v=%0b count=%0d required 0 3",
                        bus.retire_valid, bus.count);
    end
    bus.done_idx = 3'd0;
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0) begin
      n_err++; $display("FAIL inorder_latency got v=%0b required 0", bus.retire_valid);
    end
    bus.done_idx = 3'd1;
    tick();
    bus.done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.retire_valid !== 1'b1 || bus.retire_nr !== nrs[i] || bus.retire_tag !== tags[i]) begin
        n_err++; $display("FAIL inorder_retire%0d got v=%0b nr=%0d tag=%0d required 1 %0d %0d",
                          i, bus.retire_valid, bus.retire_nr, bus.retire_tag, nrs[i], tags[i]);
      end
      if (i < 2) tick();
    end
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.count !== 4'd0 || bus.retire_tag !== 5'd2) begin
      n_err++; $display("FAIL inorder_drained got v=%0b count=%0d tag=%0d required 0 0 2",
                        bus.retire_valid, bus.count, bus.retire_tag);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.alloc = 1'b1; bus.alloc_nr = 4'(i); bus.alloc_tag = 5'(10 + i);
      tick();
    end
    n_vec++;
    if (bus.full !== 1'b1 || bus.alloc_ready !== 1'b0 || bus.count !== 4'd8 || bus.alloc_idx !== 3'd0) begin
      n_err++; $display("FAIL full_state got full=%0b ready=%0b count=%0d idx=%0d required 1 0 8 0",
                        bus.full, bus.alloc_ready, bus.count, bus.alloc_idx);
    end
    bus.alloc_nr = 4'd14; bus.alloc_tag = 5'd29;
    tick();
    n_vec++;
    if (bus.count !== 4'd8 || bus.alloc_idx !== 3'd0) begin
      n_err++; $display("FAIL full_drop got count=%0d idx=%0d required 8 0", bus.count, bus.alloc_idx);
    end
    idle();
    bus.done = 1'b1; bus.done_idx = 3'd0;
    tick();
    // Retire frees a slot at this edge, but the alloc must still be refused.
    bus.alloc = 1'b1; bus.alloc_nr = 4'd15; bus.alloc_tag = 5'd30;
    bus.done_idx = 3'd1;
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 5'd10 || bus.count !== 4'd7 || bus.alloc_idx !== 3'd0) begin
      n_err++; $display("FAIL full_retire_alloc got v=%0b tag=%0d count=%0d idx=%0d required 1 10 7 0",
                        bus.retire_valid, bus.retire_tag, bus.count, bus.alloc_idx);
    end
    bus.alloc = 1'b0;
    for (int k = 2; k < 9; k++) begin
      if (k < 8) bus.done_idx = 3'(k);
      else bus.done = 1'b0;
      tick();
      n_vec++;
      if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 5'(9 + k) || bus.retire_nr !== 4'(k - 1)) begin
        n_err++; $display("FAIL full_drain%0d got v=%0b nr=%0d tag=%0d required 1 %0d %0d",
                          k, bus.retire_valid, bus.retire_nr, bus.retire_tag, k - 1, 9 + k);
      end
    end
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.empty !== 1'b1 || bus.alloc_idx !== 3'd0) begin
      n_err++; $display("FAIL full_empty got v=%0b empty=%0b idx=%0d required 0 1 0",
                        bus.retire_valid, bus.empty, bus.alloc_idx);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      n_vec++;
      if (bus.alloc_idx !== 3'(c % 8)) begin
        n_err++; $display("FAIL wrap_idx%0d got %0d required %0d", c, bus.alloc_idx, c % 8);
      end
      bus.alloc = 1'b1; bus.alloc_nr = 4'(c % 16); bus.alloc_tag = 5'(c + 1);
      bus.done = (c >= 1); bus.done_idx = 3'((c + 7) % 8);
      tick();
      n_vec++;
      if (bus.count > 4'd2) begin
        n_err++; $display("FAIL wrap_count%0d got %0d required <=2", c, bus.count);
      end
      if (c >= 2) begin
        n_vec++;
        if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 5'(c - 1)) begin
          n_err++; $display("FAIL wrap_retire%0d got v=%0b tag=%0d required 1 %0d",
                            c, bus.retire_valid, bus.retire_tag, c - 1);
        end
      end
    end
    idle();
    bus.done = 1'b1; bus.done_idx = 3'd3;
    tick();
    bus.done = 1'b0;
    n_vec++;
    if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 5'd19) begin
      n_err++; $display("FAIL wrap_tail19 got v=%0b tag=%0d required 1 19", bus.retire_valid, bus.retire_tag);
    end
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 5'd20 || bus.retire_nr !== 4'd3) begin
      n_err++; $display("FAIL wrap_tail20 got v=%0b nr=%0d tag=%0d required 1 3 20",
                        bus.retire_valid, bus.retire_nr, bus.retire_tag);
    end
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.count !== 4'd0 || bus.alloc_idx !== 3'd4) begin
      n_err++; $display("FAIL wrap_end got v=%0b count=%0d idx=%0d required 0 0 4",
                        bus.retire_valid, bus.count, bus.alloc_idx);
    end
  endtask

  task automatic test_illegal_done();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.done = 1'b1; bus.done_idx = 3'd4;
    tick();
    bus.done = 1'b0;
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.count !== 4'd0) begin
      n_err++; $display("FAIL illegal_empty got v=%0b count=%0d required 0 0", bus.retire_valid, bus.count);
    end
    bus.alloc = 1'b1; bus.alloc_nr = 4'd2; bus.alloc_tag = 5'd7;
    tick();
    bus.alloc = 1'b0;
    bus.done = 1'b1; bus.done_idx = 3'd4;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) bus.done = 1'b0;
      tick();
      if (bus.retire_valid === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses != 1 || bus.retire_tag !== 5'd7) begin
      n_err++; $display("FAIL illegal_double got pulses=%0d tag=%0d required 1 7", pulses, bus.retire_tag);
    end
    n_vec++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1) begin
      n_err++; $display("FAIL illegal_final got count=%0d empty=%0b required 0 1", bus.count, bus.empty);
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      bus.alloc = 1'b1; bus.alloc_nr = 4'(i + 1); bus.alloc_tag = 5'(i + 20);
      tick();
    end
    bus.alloc = 1'b0;
    bus.done = 1'b1; bus.done_idx = 3'd0;
    tick();
    n_vec++;
    if (bus.count !== 4'd5) begin
      n_err++; $display("FAIL flush_pre got count=%0d required 5", bus.count);
    end
    bus.flush = 1'b1; bus.alloc = 1'b1; bus.alloc_nr = 4'd9; bus.alloc_tag = 5'd31;
    bus.done_idx = 3'd1;
    tick();
    idle();
    n_vec++;
    if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.retire_valid !== 1'b0 || bus.alloc_idx !== 3'd0) begin
      n_err++; $display("FAIL flush_state got count=%0d empty=%0b v=%0b idx=%0d required 0 1 0 0",
                        bus.count, bus.empty, bus.retire_valid, bus.alloc_idx);
    end
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b0 || bus.count !== 4'd0) begin
      n_err++; $display("FAIL flush_quiet got v=%0b count=%0d required 0 0", bus.retire_valid, bus.count);
    end
    bus.alloc = 1'b1; bus.alloc_nr = 4'd9; bus.alloc_tag = 5'd17;
    tick();
    bus.alloc = 1'b0;
    bus.done = 1'b1; bus.done_idx = 3'd0;
    tick();
    bus.done = 1'b0;
    tick();
    n_vec++;
    if (bus.retire_valid !== 1'b1 || bus.retire_tag !== 5'd17 || bus.retire_nr !== 4'd9) begin
      n_err++; $display("FAIL flush_reuse got v=%0b nr=%0d tag=%0d required 1 9 17",
                        bus.retire_valid, bus.retire_nr, bus.retire_tag);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_in_order();
    test_full();
    test_wrap();
    test_illegal_done();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
